data_mem_ctl: RTL and testbench

DATA_MEM_CTL -- requirements
Module: data_mem_ctl

---
 rtl/dm_pkg.sv | 18 +
 rtl/dm_ram.sv | 29 ++
 rtl/data_mem_ctl.sv | 143 ++++++++++++++
 tb/tb_data_mem_ctl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data memory controller: access codes, FSM states, default width.
package dm_pkg;

  localparam int unsigned DM_DATA_W = 32;

  // Access size codes carried on req_size.
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dm_state_e;

endpackage

// File: rtl/dm_ram.sv
// Word-organised storage with per-byte write enables, synchronous write and combinational read.
module dm_ram
  import dm_pkg::*;
#(
  parameter int unsigned DATA_W = DM_DATA_W,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                     clk,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata_c
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write; untouched lanes keep their contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/data_mem_ctl.sv
// Data memory controller: zero-fill after reset, then byte/half/word loads and stores with alignment checking.
module data_mem_ctl
  import dm_pkg::*;
#(
  parameter int unsigned DATA_W = DM_DATA_W,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  dm_state_e         state;
  logic [IDX_W-1:0]  clr_cnt;

  logic              hs_c;
  logic              illegal_c;
  logic [1:0]        off_c;
  logic [IDX_W-1:0]  idx_c;
  logic [3:0]        be_c;
  logic [DATA_W-1:0] lane_data_c;
  logic [DATA_W-1:0] rd_word_c;
  logic [7:0]        rd_byte_c;
  logic [15:0]       rd_half_c;
  logic [DATA_W-1:0] load_data_c;
  logic [3:0]        mem_we_c;
  logic [IDX_W-1:0]  mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  assign hs_c  = req_valid && req_ready && !rst;
  assign off_c = req_addr[1:0];
  assign idx_c = IDX_W'(req_addr[ADDR_W-1:2]);

  // Legality check, lane enables and lane-replicated store data for the current request.
  always_comb begin
    illegal_c   = 1'b0;
    be_c        = 4'b0000;
    lane_data_c = req_wdata;
    case (req_size)
      SZ_B, SZ_BU: begin
        be_c        = 4'b0001 << off_c;
        lane_data_c = {4{req_wdata[7:0]}};
      end
      SZ_H, SZ_HU: begin
        illegal_c   = off_c[0];
        be_c        = off_c[1] ? 4'b1100 : 4'b0011;
        lane_data_c = {2{req_wdata[15:0]}};
      end
      SZ_W: begin
        illegal_c = (off_c != 2'b00);
        be_c      = 4'b1111;
      end
      default: illegal_c = 1'b1;
    endcase
  end

  // Memory write port is owned by the zero-fill while clearing, by legal stores otherwise.
  always_comb begin
    mem_we_c    = 4'b0000;
    mem_waddr_c = idx_c;
    mem_wdata_c = lane_data_c;
    if (!rst && state == CLEAR) begin
      mem_we_c    = 4'b1111;
      mem_waddr_c = clr_cnt;
      mem_wdata_c = '0;
    end else if (hs_c && req_we && !illegal_c) begin
      mem_we_c = be_c;
    end
  end

  dm_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we      (mem_we_c),
    .waddr   (mem_waddr_c),
    .wdata   (mem_wdata_c),
    .raddr   (idx_c),
    .rdata_c (rd_word_c)
  );

  // Lane select and sign/zero extension of the load result.
  always_comb begin
    rd_byte_c   = 8'(rd_word_c >> {off_c, 3'b000});
    rd_half_c   = off_c[1] ? rd_word_c[31:16] : rd_word_c[15:0];
    load_data_c = '0;
    case (req_size)
      SZ_B:    load_data_c = {{(DATA_W-8){rd_byte_c[7]}}, rd_byte_c};
      SZ_BU:   load_data_c = {{(DATA_W-8){1'b0}}, rd_byte_c};
      SZ_H:    load_data_c = {{(DATA_W-16){rd_half_c[15]}}, rd_half_c};
      SZ_HU:   load_data_c = {{(DATA_W-16){1'b0}}, rd_half_c};
      SZ_W:    load_data_c = rd_word_c;
      default: load_data_c = '0;
    endcase
  end

  // Control FSM and registered response; response fields hold between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= hs_c;
      if (hs_c) begin
        rsp_err   <= illegal_c;
        rsp_rdata <= (illegal_c || req_we) ? '0 : load_data_c;
      end
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + IDX_W'(1);
          if (clr_cnt == LAST_IDX) begin
            state     <= READY;
            req_ready <= 1'b1;
          end
        end
        READY: req_ready <= 1'b1;
        default: begin
          state     <= CLEAR;
          clr_cnt   <= '0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctl.sv
// Randomised and directed bench for data_mem_ctl against a byte-array reference model.
module tb_data_mem_ctl;
  import dm_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned NBYTES = DEPTH * 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  data_mem_ctl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state: byte-addressed memory plus last response fields.
  logic [7:0]  mm [NBYTES];
  logic        exp_ready;
  logic [31:0] exp_rdata;
  logic        exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic is_legal(input logic [2:0] sz, input int a);
    case (sz)
      SZ_B, SZ_BU: return 1'b1;
      SZ_H, SZ_HU: return (a % 2) == 0;
      SZ_W:        return (a % 4) == 0;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] sz, input int a);
    logic [7:0]  b;
    logic [15:0] h;
    b = mm[a];
    h = {mm[(a + 1) % NBYTES], mm[a]};
    case (sz)
      SZ_B:    return 32'($signed(b));
      SZ_BU:   return 32'(b);
      SZ_H:    return 32'($signed(h));
      SZ_HU:   return 32'(h);
      SZ_W:    return {mm[a + 3], mm[a + 2], mm[a + 1], mm[a]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] sz, input int a, input logic [31:0] wd);
    case (sz)
      SZ_B, SZ_BU: mm[a] = wd[7:0];
      SZ_H, SZ_HU: begin mm[a] = wd[7:0]; mm[a + 1] = wd[15:8]; end
      default: begin
        mm[a] = wd[7:0]; mm[a + 1] = wd[15:8]; mm[a + 2] = wd[23:16]; mm[a + 3] = wd[31:24];
      end
    endcase
  endtask

  // One clock of traffic: predict from the model, advance the clock, compare all outputs.
  task automatic step(input logic v, input logic we, input logic [2:0] sz,
                      input logic [ADDR_W-1:0] a, input logic [31:0] wd);
    logic ev;
    req_valid = v; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
    ev = v && exp_ready;
    if (ev) begin
      exp_err   = !is_legal(sz, int'(a));
      exp_rdata = (exp_err || we) ? 32'h0 : model_load(sz, int'(a));
      if (!exp_err && we) model_store(sz, int'(a), wd);
    end
    @(posedge clk); #1;
    check("rsp_valid", 32'(rsp_valid), 32'(ev));
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_err",   32'(rsp_err), 32'(exp_err));
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    req_valid = 1'b0;
  endtask

  // Count cycles from reset release to the first req_ready, with a bounded wait.
  task automatic wait_ready(input string tag);
    int cnt;
    logic saw_rsp;
    cnt = 0;
    saw_rsp = 1'b0;
    while (!req_ready && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check(tag, 32'(cnt), 32'(DEPTH));
    check("clear_no_rsp", 32'(saw_rsp), 32'h0);
    for (int i = 0; i < int'(NBYTES); i++) mm[i] = 8'h00;
    exp_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_valid", 32'(rsp_valid), 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err",   32'(rsp_err), 32'h0);
    exp_ready = 1'b0; exp_rdata = 32'h0; exp_err = 1'b0;
    wait_ready("ready_latency");
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_W;
    req_addr = '0; req_wdata = '0;
    exp_ready = 1'b0; exp_rdata = 32'h0; exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Freshly cleared memory reads zero at the top word.
    step(1, 0, SZ_W, 7'h7C, 32'h0);
    check("top_word_zero", rsp_rdata, 32'h0);

    // Byte extraction from a stored word.
    step(1, 1, SZ_W,  7'h10, 32'hDEADBEEF);
    step(1, 0, SZ_BU, 7'h13, 32'h0);
    check("bu_0x13", rsp_rdata, 32'h000000DE);
    step(1, 0, SZ_B,  7'h13, 32'h0);
    check("b_0x13", rsp_rdata, 32'hFFFFFFDE);

    // Half store merges into the upper lanes only.
    step(1, 1, SZ_W, 7'h20, 32'h11223344);
    step(1, 1, SZ_H, 7'h22, 32'h00008001);
    step(1, 0, SZ_W, 7'h20, 32'h0);
    check("merge_word", rsp_rdata, 32'h80013344);
    step(1, 0, SZ_H, 7'h22, 32'h0);
    check("h_0x22", rsp_rdata, 32'hFFFF8001);

    // Misaligned accesses are rejected without touching memory.
    step(1, 1, SZ_W, 7'h04, 32'h12345678);
    step(1, 1, SZ_W, 7'h05, 32'hCAFEF00D);
    check("mis_st_err", 32'(rsp_err), 32'h1);
    step(1, 0, SZ_H, 7'h03, 32'h0);
    check("mis_ld_err", 32'(rsp_err), 32'h1);
    check("mis_ld_data", rsp_rdata, 32'h0);
    step(1, 0, SZ_W, 7'h04, 32'h0);
    check("word4_kept", rsp_rdata, 32'h12345678);
    step(1, 0, 3'b011, 7'h00, 32'h0);
    check("bad_size_err", 32'(rsp_err), 32'h1);

    // Store followed immediately by a load of the same word.
    step(1, 1, SZ_W, 7'h08, 32'hA5A5A5A5);
    check("b2b_st_valid", 32'(rsp_valid), 32'h1);
    step(1, 0, SZ_W, 7'h08, 32'h0);
    check("b2b_ld_valid", 32'(rsp_valid), 32'h1);
    check("b2b_ld_data", rsp_rdata, 32'hA5A5A5A5);

    // Randomised traffic with idle gaps.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom),
           7'($urandom), $urandom);
    end

    // Reset during an in-flight load, then again mid-clear.
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_addr = 7'h10; rst = 1'b1;
    @(posedge clk); #1;
    check("rst_drop_valid", 32'(rsp_valid), 32'h0);
    check("rst_drop_ready", 32'(req_ready), 32'h0);
    rst = 1'b0; req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midclear_ready", 32'(req_ready), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ready = 1'b0; exp_rdata = 32'h0; exp_err = 1'b0;
    wait_ready("restart_latency");
    for (int w = 0; w < int'(DEPTH); w++) begin
      step(1, 0, SZ_W, 7'(w * 4), 32'h0);
      check("cleared_word", rsp_rdata, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
